// File: rtl/injector.sv
// Local-node injection stage of the deflection router: queues core flits
// and drops the head flit into the first empty channel slot.
`ifndef STEER_W
`define STEER_W 16
`endif
`ifndef VALID_F
`define VALID_F 15
`endif

module injector #(
    parameter int DEPTH     = 4,
    parameter int STARVE_TH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [`STEER_W-1:0] in_flit,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [`STEER_W-1:0] c0,
    input  logic [`STEER_W-1:0] c1,
    input  logic [`STEER_W-1:0] c2,
    input  logic [`STEER_W-1:0] c3,
    output logic [`STEER_W-1:0] c0_o,
    output logic [`STEER_W-1:0] c1_o,
    output logic [`STEER_W-1:0] c2_o,
    output logic [`STEER_W-1:0] c3_o,
    output logic                starved,
    output logic                inj_fire
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [7:0] TH = 8'(STARVE_TH);

    logic [`STEER_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       rd_q, rd_d;
    logic [AW-1:0]       wr_q, wr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          stv_q, stv_d;
    logic                starved_q, starved_d;

    logic                push;
    logic                head_vld;
    logic [3:0]          free;
    logic [3:0]          sel;
    logic [`STEER_W-1:0] head;
    logic [`STEER_W-1:0] vmask;

    assign vmask    = `STEER_W'(1) << `VALID_F;
    assign in_ready = (cnt_q != FULL);
    assign push     = in_valid && in_ready && rst_n;
    assign head_vld = (cnt_q != '0);
    assign head     = mem_q[rd_q];

    assign free[0] = ~c0[`VALID_F];
    assign free[1] = ~c1[`VALID_F];
    assign free[2] = ~c2[`VALID_F];
    assign free[3] = ~c3[`VALID_F];

    // One-hot of the lowest-index empty slot.
    assign sel[0] = free[0];
    assign sel[1] = free[1] & ~free[0];
    assign sel[2] = free[2] & ~|free[1:0];
    assign sel[3] = free[3] & ~|free[2:0];

    assign inj_fire = head_vld && (|free) && rst_n;
    assign starved  = starved_q;

    always_comb begin
        c0_o = c0;
        c1_o = c1;
        c2_o = c2;
        c3_o = c3;
        if (inj_fire) begin
            unique case (1'b1)
                sel[0]:  c0_o = head;
                sel[1]:  c1_o = head;
                sel[2]:  c2_o = head;
                sel[3]:  c3_o = head;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + AW'(1);
        if (inj_fire) rd_d = rd_q + AW'(1);
        unique case ({push, inj_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
    end

    always_comb begin
        stv_d = stv_q;
        if (inj_fire || !head_vld) begin
            stv_d = '0;
        end else if (!(|free)) begin
            stv_d = (stv_q >= TH) ? stv_q : stv_q + 8'd1;
        end
        starved_d = (stv_d >= TH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            stv_q     <= '0;
            starved_q <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            stv_q     <= stv_d;
            starved_q <= starved_d;
        end
    end

    // Storage needs no reset; the count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_flit | vmask;
    end

endmodule

// File: tb/tb_injector.sv
// Bench for injector: directed scenarios then random traffic, each cycle
// compared against a queue-based reference model.
`ifndef STEER_W
`define STEER_W 16
`endif
`ifndef VALID_F
`define VALID_F 15
`endif

module tb_injector;

    localparam int DEPTH = 4;
    localparam int TH    = 8;
    localparam int W     = `STEER_W;
    localparam logic [W-1:0] V = W'(1) << `VALID_F;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_flit;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] c0, c1, c2, c3;
    logic [W-1:0] c0_o, c1_o, c2_o, c3_o;
    logic         starved;
    logic         inj_fire;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] q[$];
    int           m_stv = 0;
    logic         m_starved = 1'b0;

    always #5 clk = ~clk;

    injector #(.DEPTH(DEPTH), .STARVE_TH(TH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3),
        .c0_o(c0_o), .c1_o(c1_o), .c2_o(c2_o), .c3_o(c3_o),
        .starved(starved), .inj_fire(inj_fire)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational/registered outputs, advance model.
    task automatic step(input logic r, input logic v, input logic [W-1:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] ci [4];
        logic [W-1:0] eo [4];
        int  k;
        bit  fire, rdy, anyfree, was_empty;
        rst_n = r; in_valid = v; in_flit = f;
        c0 = a; c1 = b; c2 = c; c3 = d;
        ci[0] = a; ci[1] = b; ci[2] = c; ci[3] = d;
        eo = ci;
        k = -1;
        for (int i = 0; i < 4; i++)
            if (k < 0 && !ci[i][`VALID_F]) k = i;
        anyfree = (k >= 0);
        was_empty = (q.size() == 0);
        fire = r && !was_empty && anyfree;
        rdy = (q.size() < DEPTH);
        if (fire) eo[k] = q[0];
        @(negedge clk);
        chk("in_ready", W'(in_ready), W'(rdy));
        chk("inj_fire", W'(inj_fire), W'(fire));
        chk("c0_o", c0_o, eo[0]);
        chk("c1_o", c1_o, eo[1]);
        chk("c2_o", c2_o, eo[2]);
        chk("c3_o", c3_o, eo[3]);
        chk("starved", W'(starved), W'(m_starved));
        @(posedge clk);
        if (!r) begin
            q.delete();
            m_stv = 0;
            m_starved = 1'b0;
        end else begin
            if (fire) void'(q.pop_front());
            if (v && rdy) q.push_back(f | V);
            if (fire || was_empty) m_stv = 0;
            else if (!anyfree && m_stv < TH) m_stv++;
            m_starved = (m_stv >= TH);
        end
        #1;
    endtask

    function automatic logic [W-1:0] rnd_ch();
        logic [W-1:0] x;
        x = W'($urandom);
        if ($urandom_range(0, 2) == 0) x = x & ~V;
        else x = x | V;
        return x;
    endfunction

    initial begin
        logic [W-1:0] fa, full, z;
        rst_n = 1'b0; in_valid = 1'b0; in_flit = '0;
        c0 = '0; c1 = '0; c2 = '0; c3 = '0;
        z = '0;
        full = V | W'(16'h0123);
        @(posedge clk); #1;

        step(0, 0, z, z, z, z, z);
        step(0, 1, W'(16'h1111), z, z, z, z);

        // Single flit A (dest=3) into an idle network.
        fa = W'(16'h6042);
        step(1, 1, fa, z, z, z, z);
        step(1, 0, z, z, z, z, z);
        step(1, 0, z, z, z, z, z);

        // Fill the FIFO while every channel is occupied.
        for (int i = 0; i < 4; i++)
            step(1, 1, W'(16'h0100 + i), full, full, full, full);
        step(1, 1, W'(16'h0BAD), full, full, full, full);
        step(1, 0, z, full, full, z, full);
        step(1, 0, z, full, full, full, full);

        // Starve the head past the threshold, then release on c3.
        for (int i = 0; i < 10; i++)
            step(1, 0, z, full, full, full, full);
        step(1, 0, z, full, full, full, z);
        step(1, 0, z, full, full, full, full);

        // Drain to one flit, then push+pop pairs across pointer wrap.
        while (q.size() > 1) step(1, 0, z, z, full, full, full);
        for (int i = 0; i < 6; i++)
            step(1, 1, W'(16'h0200 + i), z, full, full, full);
        step(1, 0, z, z, z, z, z);

        // Three flits queued and starved, then reset mid-operation.
        for (int i = 0; i < 3; i++)
            step(1, 1, W'(16'h0300 + i), full, full, full, full);
        for (int i = 0; i < 9; i++)
            step(1, 0, z, full, full, full, full);
        step(0, 1, W'(16'h0399), z, full, z, full);
        step(0, 0, z, z, z, z, z);
        step(1, 0, z, z, z, z, z);

        // Two queued, c1 and c3 both free.
        step(1, 1, W'(16'h0401), full, full, full, full);
        step(1, 1, W'(16'h0402), full, full, full, full);
        step(1, 0, z, full, z, full, z);
        step(1, 0, z, full, full, full, full);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 60) != 0, $urandom_range(0, 1) == 1,
                 W'($urandom), rnd_ch(), rnd_ch(), rnd_ch(), rnd_ch());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/injector.md
Name: injector

Overview:
- Local-node injection stage of the bufferless deflection router. It is the counterpart of the ejection stage.
- Buffers locally generated flits in a small FIFO. Each cycle it inserts the head flit into the first empty slot among the four channel flits leaving the ejection stage.
- Tracks injection starvation, so the local core can be throttled when the ring or mesh is saturated.

Parameters:
- DEPTH, 4, injection FIFO depth in flits; power of two, at least 2.
- STARVE_TH, 8, consecutive blocked cycles before `starved` asserts; at least 1, fits in 8 bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_flit  input  `steer_w  flit from local core.
- in_valid  input  1  in_flit is valid.
- in_ready  output  1  FIFO can accept a flit this cycle.
- c0  input  `steer_w  channel 0 flit, post-ejection.
- c1  input  `steer_w  channel 1 flit, post-ejection.
- c2  input  `steer_w  channel 2 flit, post-ejection.
- c3  input  `steer_w  channel 3 flit, post-ejection.
- c0_o  output  `steer_w  channel 0 flit after injection.
- c1_o  output  `steer_w  channel 1 flit after injection.
- c2_o  output  `steer_w  channel 2 flit after injection.
- c3_o  output  `steer_w  channel 3 flit after injection.
- starved  output  1  head flit blocked for at least STARVE_TH consecutive cycles.
- inj_fire  output  1  a flit was injected this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - FIFO read pointer, write pointer and count go to 0.
  - Starvation counter goes to 0; `starved` goes to 0.
  - While rst_n=0, no injection: cN_o = cN, inj_fire=0, and no push is accepted.
  - Asserting reset mid-operation discards all queued flits.
- FIFO:
  - in_ready = (count != DEPTH). It is combinational from registered count, and is 1 out of reset.
  - Push when in_valid && in_ready && rst_n.
  - On push, the stored flit has its `valid_f bit forced to 1.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - No bypass: a flit pushed in cycle N is first injectable in cycle N+1.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any count, including full (no push possible) and count=1.
- Slot selection (combinational):
  - free_k = ~ck[`valid_f].
  - Head present = count != 0.
  - Fixed priority c0 > c1 > c2 > c3. Inject into the lowest-index free channel only.
  - Outputs: c_k_o = head flit for the selected k; all other channels pass through unchanged.
  - At most one injection per cycle.
  - inj_fire = head present && any free_k && rst_n. inj_fire pops the FIFO at the edge.
  - A free slot with no head flit passes the empty flit through unchanged.
- Starvation counter (8-bit, saturating at STARVE_TH):
  - Head present and no free slot: increment.
  - inj_fire or FIFO empty: clear to 0.
  - `starved` is registered: starved_next = (counter_next >= STARVE_TH).
  - It deasserts the cycle after the first successful injection.
- inj_fire, in_ready and cN_o are combinational. starved is registered.

Test Plan:
- Reset, then push A (dest=3) in cycle 1 with all cN invalid.
  - Required: in cycle 2, c0_o=A with valid=1, c1_o..c3_o = inputs, inj_fire=1, count back to 0.
- Push 4 flits with all channels valid (DEPTH=4).
  - Required: in_ready=0 after the 4th push.
  - Free c2 only: the head goes to c2_o, and in_ready=1 the next cycle.
- Keep all channels valid for 10 cycles with a head present (STARVE_TH=8).
  - Required: starved=1 from the end of the 8th blocked cycle onward.
  - Free c3: c3_o=head, and starved=0 the next cycle.
- At count=1, push B while injecting the head.
  - Required: count stays 1, B is the head next cycle, FIFO order is preserved across pointer wrap after 6 push/pop pairs.
- Drive rst_n=0 with 3 flits queued and starved=1.
  - Required: same edge gives count=0 and starved=0; while rst_n=0, cN_o=cN and inj_fire=0.
- Free c1 and c3 simultaneously with 2 flits queued.
  - Required: only c1_o carries the head, c3_o stays invalid, exactly one pop.
